monitor_poll_sched: RTL and testbench

Polling scheduler for the power-monitor UART link. It periodically walks a set of monitored supply channels and sends each one a fixed query frame through the shared UART transmitter. It then waits for the receive-side frame parser to report the matching reply, with per-channel timeout, retry and fault tracking. It sits beside the receive path in the power-monitor top and owns the UART TX port and the parsed-data output register.

---
 rtl/monitor_poll_sched.sv | 158 +++++++++++++++
 tb/tb_monitor_poll_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_poll_sched.sv
// Poll scheduler: sends query frames to each monitored channel over the shared UART TX, tracks replies, retries and faults.
// Define MONITOR_POLL_CHKSUM_EN for 5-byte frames ending in a checksum; otherwise frames are 4 bytes.
module monitor_poll_sched #(
   parameter int unsigned CH_NUM      = 4,
   parameter logic [7:0]  ADDR_BASE   = 8'h10,
   parameter int unsigned POLL_PERIOD = 60000,
   parameter int unsigned RSP_TIMEOUT = 6000,
   parameter int unsigned MAX_RETRY   = 2
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              poll_en,
   input  logic              tx_rdy,
   output logic              tx_en,
   output logic [7:0]        tx_data,
   input  logic              rsp_valid,
   input  logic [7:0]        rsp_addr,
   input  logic [95:0]       rsp_data,
   output logic [95:0]       data_ov,
   output logic [3:0]        data_ch,
   output logic              data_upd,
   output logic [CH_NUM-1:0] ch_fault,
   output logic              busy,
   output logic              poll_overrun
);

`ifdef MONITOR_POLL_CHKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd4;
`else
   localparam logic [2:0] LAST_IDX = 3'd3;
`endif
   localparam int unsigned PW = $clog2(POLL_PERIOD);
   localparam int unsigned TW = $clog2(RSP_TIMEOUT);
   localparam int unsigned CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   typedef enum logic [2:0] {IDLE, SEND, GUARD, WAIT_TX, WAIT_RSP, NEXT} state_t;

   state_t          state;
   logic [PW-1:0]   pcnt;
   logic [TW-1:0]   tcnt;
   logic [CW-1:0]   ch;
   logic [2:0]      retry;
   logic [2:0]      idx;
   logic            gcnt;
   logic            tick;
   logic [7:0]      addr;
   logic [7:0]      cs;
   logic [7:0]      frame_byte;
   logic            rsp_match;

   assign tick      = poll_en && (pcnt == PW'(POLL_PERIOD - 1));
   assign addr      = ADDR_BASE + 8'(ch);
   assign cs        = 8'hEB + 8'h90 + addr + 8'h01;
   assign rsp_match = rsp_valid && (rsp_addr == addr);

   // The byte strobe follows SEND directly so the UART sees it in the same cycle tx_rdy is qualified.
   assign tx_en   = (state == SEND) && tx_rdy;
   assign tx_data = tx_en ? frame_byte : '0;

   always_comb begin
      frame_byte = 8'hEB;
      case (idx)
         3'd0:    frame_byte = 8'hEB;
         3'd1:    frame_byte = 8'h90;
         3'd2:    frame_byte = addr;
         3'd3:    frame_byte = 8'h01;
         default: frame_byte = cs;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (rst || !poll_en || tick) pcnt <= '0;
      else                         pcnt <= pcnt + 1'b1;
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state        <= IDLE;
         ch           <= '0;
         retry        <= '0;
         idx          <= '0;
         gcnt         <= 1'b0;
         tcnt         <= '0;
         data_ov      <= '0;
         data_ch      <= '0;
         data_upd     <= 1'b0;
         ch_fault     <= '0;
         busy         <= 1'b0;
         poll_overrun <= 1'b0;
      end else begin
         data_upd <= 1'b0;
         if (tick && state != IDLE) poll_overrun <= 1'b1;
         case (state)
            IDLE: if (tick) begin
               state <= SEND;
               ch    <= '0;
               retry <= '0;
               idx   <= '0;
               busy  <= 1'b1;
            end
            SEND: if (tx_rdy) begin
               gcnt  <= 1'b0;
               state <= GUARD;
            end
            GUARD: begin
               gcnt <= 1'b1;
               if (gcnt) state <= WAIT_TX;
            end
            WAIT_TX: if (tx_rdy) begin
               if (idx == LAST_IDX) begin
                  tcnt  <= '0;
                  state <= WAIT_RSP;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= SEND;
               end
            end
            WAIT_RSP: begin
               tcnt <= tcnt + 1'b1;
               // A matching reply on the timeout cycle takes priority over retry/fault.
               if (rsp_match) begin
                  data_ov      <= rsp_data;
                  data_ch      <= 4'(ch);
                  data_upd     <= 1'b1;
                  ch_fault[ch] <= 1'b0;
                  state        <= NEXT;
               end else if (tcnt == TW'(RSP_TIMEOUT - 1)) begin
                  if (retry < 3'(MAX_RETRY)) begin
                     retry <= retry + 1'b1;
                     idx   <= '0;
                     state <= SEND;
                  end else begin
                     ch_fault[ch] <= 1'b1;
                     state        <= NEXT;
                  end
               end
            end
            NEXT: begin
               retry <= '0;
               idx   <= '0;
               if (ch == CW'(CH_NUM - 1) || !poll_en) begin
                  ch    <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  ch    <= ch + 1'b1;
                  state <= SEND;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_monitor_poll_sched.sv
// Self-checking bench for monitor_poll_sched: directed reply tables plus randomized rounds against an attempt-level model.
module tb_monitor_poll_sched;
   localparam int         CHN = 4;
   localparam logic [7:0] AB  = 8'h10;
   localparam int         P   = 1000;
   localparam int         T   = 200;
   localparam int         MR  = 1;
`ifdef MONITOR_POLL_CHKSUM_EN
   localparam int FLEN = 5;
`else
   localparam int FLEN = 4;
`endif

   logic           sclk = 1'b0;
   logic           rst = 1'b1;
   logic           poll_en = 1'b0;
   logic           tx_rdy = 1'b1;
   logic           rsp_valid = 1'b0;
   logic [7:0]     rsp_addr = '0;
   logic [95:0]    rsp_data = '0;
   logic           tx_en;
   logic [7:0]     tx_data;
   logic [95:0]    data_ov;
   logic [3:0]     data_ch;
   logic           data_upd;
   logic [CHN-1:0] ch_fault;
   logic           busy;
   logic           poll_overrun;

   monitor_poll_sched #(
      .CH_NUM(CHN), .ADDR_BASE(AB), .POLL_PERIOD(P), .RSP_TIMEOUT(T), .MAX_RETRY(MR)
   ) dut (
      .sclk(sclk), .rst(rst), .poll_en(poll_en), .tx_rdy(tx_rdy),
      .tx_en(tx_en), .tx_data(tx_data),
      .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .data_ov(data_ov), .data_ch(data_ch), .data_upd(data_upd),
      .ch_fault(ch_fault), .busy(busy), .poll_overrun(poll_overrun)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      int ch;
      int d0;
      int d1;
      bit wrong0;
      int exp_upd;
      bit exp_fault;
   } vec_t;

   int             errors = 0;
   int             checks = 0;
   int             n_upd = 0;
   int             cyc = 0;
   int             last_tx = -100;
   int             wait0 = 0;
   logic [CHN-1:0] m_fault = '0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   function automatic logic [7:0] addr_of(input int ch);
      return 8'((32'(AB) + 32'(ch)) % 256);
   endfunction

   always @(posedge sclk) begin
      #1;
      cyc++;
      if (tx_en === 1'b1) begin
         chk("tx_gap_short", 96'((cyc - last_tx) < 4), 96'd0);
         last_tx = cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Collects one frame from the tx strobes and compares it with the query expected for channel ch.
   task automatic get_frame(input int ch, input int budget, output int first_w);
      logic [39:0] got_p, exp_p;
      logic [7:0]  eb[5];
      int n, w;
      eb[0] = 8'hEB;
      eb[1] = 8'h90;
      eb[2] = addr_of(ch);
      eb[3] = 8'h01;
      eb[4] = 8'((32'h0EB + 32'h090 + 32'(eb[2]) + 32'h001) % 256);
      got_p = '0;
      exp_p = '0;
      n = 0;
      w = 0;
      first_w = -1;
      while (n < FLEN && w < budget + 5 * FLEN) begin
         step();
         w++;
         if (tx_en === 1'b1) begin
            if (n == 0) first_w = w;
            got_p = {got_p[31:0], tx_data};
            n++;
         end
      end
      chk("frame_len", 96'(n), 96'(FLEN));
      for (int i = 0; i < FLEN; i++) exp_p = {exp_p[31:0], eb[i]};
      chk("frame_bytes", 96'(got_p), 96'(exp_p));
   endtask

   // One query/reply attempt; d<0 means the channel stays silent.
   task automatic attempt(input int ch, input int d, input bit wrong, input int budget,
                          input int drop_at, output bit ok, output int first_w);
      logic [95:0] pay;
      bit hit;
      ok = 1'b0;
      get_frame(ch, budget, first_w);
      if (d < 0) return;
      for (int i = 0; i < d; i++) begin
         if (i == drop_at) poll_en = 1'b0;
         step();
      end
      pay = {$urandom, $urandom, $urandom};
      rsp_valid = 1'b1;
      rsp_addr  = wrong ? addr_of((ch + 1) % CHN) : addr_of(ch);
      rsp_data  = pay;
      step();
      rsp_valid = 1'b0;
      rsp_addr  = '0;
      rsp_data  = '0;
      // Reply window opens 4 cycles after the last byte strobe and closes on the timeout cycle.
      hit = !wrong && d >= 4 && d <= T + 3;
      chk("data_upd", 96'(data_upd), 96'(hit));
      n_upd += int'(data_upd);
      if (hit) begin
         chk("data_ch", 96'(data_ch), 96'(ch));
         chk("data_ov", data_ov, pay);
         chk("fault_clear", 96'(ch_fault[ch]), 96'd0);
         m_fault[ch] = 1'b0;
      end
      ok = hit;
   endtask

   task automatic serve(input int ch, input int d0, input int d1, input bit wrong0, input int budget0);
      bit ok;
      int d, w, fw;
      ok = 1'b0;
      d = -1;
      for (int a = 0; a <= MR; a++) begin
         d = (a == 0) ? d0 : d1;
         attempt(ch, d, (a == 0) && wrong0, (a == 0) ? budget0 : T + 60, -1, ok, fw);
         if (a == 0) wait0 = fw;
         if (ok) break;
      end
      if (!ok) begin
         if (d < 0) begin
            repeat (T + 3) step();
            chk("fault_early", 96'(ch_fault[ch]), 96'(m_fault[ch]));
            step();
         end else begin
            w = 0;
            while (ch_fault[ch] !== 1'b1 && w < T + 10) begin
               step();
               w++;
            end
         end
         chk("fault_set", 96'(ch_fault[ch]), 96'd1);
         m_fault[ch] = 1'b1;
      end
      if (ch == CHN - 1) begin
         step();
         chk("busy_round_end", 96'(busy), 96'd0);
      end
   endtask

   initial begin
      vec_t tbl[12];
      int   u0, cnt, fw, d0, d1, mode;
      bit   ok, wr;

      // Round A: every channel answers. Round B: wrong address, timeout-cycle reply, silent channel.
      // Round C: channel 2 recovers.
      tbl[0]  = '{0, 10,    -1, 1'b0, 1, 1'b0};
      tbl[1]  = '{1, 10,    -1, 1'b0, 1, 1'b0};
      tbl[2]  = '{2, 10,    -1, 1'b0, 1, 1'b0};
      tbl[3]  = '{3, 10,    -1, 1'b0, 1, 1'b0};
      tbl[4]  = '{0, 10,    10, 1'b1, 1, 1'b0};
      tbl[5]  = '{1, T + 3, -1, 1'b0, 1, 1'b0};
      tbl[6]  = '{2, -1,    -1, 1'b0, 0, 1'b1};
      tbl[7]  = '{3, 10,    -1, 1'b0, 1, 1'b0};
      tbl[8]  = '{0, 10,    -1, 1'b0, 1, 1'b0};
      tbl[9]  = '{1, 10,    -1, 1'b0, 1, 1'b0};
      tbl[10] = '{2, 10,    -1, 1'b0, 1, 1'b0};
      tbl[11] = '{3, 10,    -1, 1'b0, 1, 1'b0};

      repeat (3) step();
      chk("rst_tx_en", 96'(tx_en), 96'd0);
      chk("rst_tx_data", 96'(tx_data), 96'd0);
      chk("rst_data_ov", data_ov, 96'd0);
      chk("rst_data_ch", 96'(data_ch), 96'd0);
      chk("rst_data_upd", 96'(data_upd), 96'd0);
      chk("rst_ch_fault", 96'(ch_fault), 96'd0);
      chk("rst_busy", 96'(busy), 96'd0);
      chk("rst_overrun", 96'(poll_overrun), 96'd0);
      rst = 1'b0;

      poll_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         u0 = n_upd;
         serve(tbl[i].ch, tbl[i].d0, tbl[i].d1, tbl[i].wrong0, (tbl[i].ch == 0) ? 2 * P + 100 : T + 60);
         if (i == 0) chk("first_tx_latency", 96'(wait0), 96'(P));
         chk("upd_count", 96'(n_upd - u0), 96'(tbl[i].exp_upd));
         chk("fault_bit", 96'(ch_fault[tbl[i].ch]), 96'(tbl[i].exp_fault));
         if (i % 4 == 3) chk("ch_fault_vec", 96'(ch_fault), 96'(m_fault));
      end

      // Transmitter stalled: the round cannot start sending and later ticks are dropped.
      tx_rdy = 1'b0;
      cnt = 0;
      while (busy !== 1'b1 && cnt < 2 * P + 100) begin
         step();
         cnt++;
      end
      chk("stall_busy", 96'(busy), 96'd1);
      cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         step();
         cnt += int'(tx_en);
      end
      chk("stall_no_tx", 96'(cnt), 96'd0);
      chk("stall_overrun", 96'(poll_overrun), 96'd1);

      tx_rdy = 1'b1;
      #1;
      cnt = int'(tx_en);
      for (int i = 0; i < 20 && cnt < 2; i++) begin
         step();
         cnt += int'(tx_en);
      end
      chk("midframe_bytes", 96'(cnt), 96'd2);
      rst = 1'b1;
      step();
      chk("mrst_tx_en", 96'(tx_en), 96'd0);
      chk("mrst_tx_data", 96'(tx_data), 96'd0);
      chk("mrst_data_ov", data_ov, 96'd0);
      chk("mrst_data_ch", 96'(data_ch), 96'd0);
      chk("mrst_ch_fault", 96'(ch_fault), 96'd0);
      chk("mrst_busy", 96'(busy), 96'd0);
      chk("mrst_overrun", 96'(poll_overrun), 96'd0);
      rst = 1'b0;
      m_fault = '0;

      // poll_en dropped while channel 1 waits for its reply.
      serve(0, 10, -1, 1'b0, 2 * P + 100);
      attempt(1, 10, 1'b0, T + 60, 5, ok, fw);
      step();
      chk("drop_busy", 96'(busy), 96'd0);
      cnt = 0;
      for (int i = 0; i < 1500; i++) begin
         step();
         cnt += int'(tx_en);
      end
      chk("drop_no_tx", 96'(cnt), 96'd0);

      poll_en = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < CHN; c++) begin
            mode = int'($urandom_range(0, 3));
            d1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, T + 3)) : -1;
            case (mode)
               0: begin d0 = -1; wr = 1'b0; end
               1: begin d0 = int'($urandom_range(4, T)); wr = 1'b1; end
               default: begin d0 = int'($urandom_range(4, T + 3)); wr = 1'b0; end
            endcase
            serve(c, d0, d1, wr, (c == 0) ? 2 * P + 100 : T + 60);
         end
         chk("rand_ch_fault", 96'(ch_fault), 96'(m_fault));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
